// File: rtl/shapool_serial_ctrl.sv
// Host serial controller for the hashing pool.
// Loads job/ID, runs the core, shifts {success, nonce} back out.
module shapool_serial_ctrl #(
  parameter int JOB_BITS     = 64,
  parameter int DAISY_BITS   = 8,
  parameter int NONCE_BITS   = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int LED_DIV_LOG2 = 22
) (
  input  logic                  hwclk,
  input  logic                  reset_in,
  input  logic                  data_clk,
  input  logic                  data_in,
  output logic                  data_out,
  output logic                  data_out_oe,
  input  logic                  daisy_sel,
  input  logic                  daisy_in,
  output logic                  daisy_out,
  input  logic                  done_in,
  output logic                  done_out,
  input  logic                  success_in,
  output logic                  success_oe,
  output logic [JOB_BITS-1:0]   core_job,
  output logic [DAISY_BITS-1:0] core_id,
  output logic                  core_start,
  output logic                  core_halt,
  input  logic                  core_done,
  input  logic                  core_success,
  input  logic [NONCE_BITS-1:0] core_nonce,
  output logic                  status_led,
  output logic                  success_led,
  output logic                  load_err
);

  localparam int JCW = $clog2(JOB_BITS + 1);
  localparam int DCW = $clog2(DAISY_BITS + 1);
  localparam int RCW = $clog2(NONCE_BITS + 2);
  localparam int RW  = NONCE_BITS + 1;
  localparam int LCW = LED_DIV_LOG2 + 1;

  localparam logic [JCW-1:0] J_FULL = JCW'(JOB_BITS);
  localparam logic [DCW-1:0] D_FULL = DCW'(DAISY_BITS);
  localparam logic [RCW-1:0] R_LAST = RCW'(NONCE_BITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  logic [5:0]                  async_in;
  logic [5:0][SYNC_STAGES-1:0] sync_q;
  logic dclk_s, din_s, sel_s, dyin_s, done_s, succ_s;
  logic dclk_q, sel_q;
  logic dclk_rise, sel_fall;

  state_t                state;
  logic [JOB_BITS-1:0]   job_reg;
  logic [DAISY_BITS-1:0] daisy_reg;
  logic [JCW-1:0]        jcnt;
  logic [DCW-1:0]        dcnt;
  logic [RCW-1:0]        rcnt;
  logic [RW-1:0]         result;
  logic [LCW-1:0]        led_cnt;
  logic                  local_done;

  assign async_in = {success_in, done_in, daisy_in,
                     daisy_sel, data_in, data_clk};

  assign dclk_s = sync_q[0][SYNC_STAGES-1];
  assign din_s  = sync_q[1][SYNC_STAGES-1];
  assign sel_s  = sync_q[2][SYNC_STAGES-1];
  assign dyin_s = sync_q[3][SYNC_STAGES-1];
  assign done_s = sync_q[4][SYNC_STAGES-1];
  assign succ_s = sync_q[5][SYNC_STAGES-1];

  assign dclk_rise = dclk_s & ~dclk_q;
  assign sel_fall  = sel_q & ~sel_s;

  assign core_job  = job_reg;
  assign core_id   = daisy_reg;
  assign daisy_out = daisy_reg[DAISY_BITS-1];
  assign data_out  = result[RW-1];

  // Synchronise every pin and keep edge-detect history.
  always_ff @(posedge hwclk) begin
    if (!reset_in) begin
      sync_q <= '0;
      dclk_q <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
      dclk_q <= dclk_s;
      sel_q  <= sel_s;
    end
  end

  // Load / run / report sequencer with registered outputs.
  always_ff @(posedge hwclk) begin
    if (!reset_in) begin
      state       <= IDLE;
      job_reg     <= '0;
      daisy_reg   <= '0;
      jcnt        <= '0;
      dcnt        <= '0;
      rcnt        <= '0;
      result      <= '0;
      led_cnt     <= '0;
      local_done  <= 1'b0;
      core_start  <= 1'b0;
      core_halt   <= 1'b0;
      success_led <= 1'b0;
      success_oe  <= 1'b0;
      data_out_oe <= 1'b0;
      load_err    <= 1'b0;
      status_led  <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      core_halt  <= 1'b0;
      done_out   <= local_done & done_s;
      unique case (state)
        IDLE: begin
          status_led <= 1'b0;
          if (sel_fall) begin
            if (jcnt == J_FULL && dcnt == D_FULL) begin
              state       <= RUN;
              load_err    <= 1'b0;
              core_start  <= 1'b1;
              success_led <= 1'b0;
              led_cnt     <= '0;
            end else begin
              load_err <= 1'b1;
              jcnt     <= '0;
              dcnt     <= '0;
            end
          end else if (dclk_rise) begin
            if (sel_s) begin
              daisy_reg <= {daisy_reg[DAISY_BITS-2:0], dyin_s};
              if (dcnt != D_FULL) dcnt <= dcnt + 1'b1;
            end else begin
              job_reg <= {job_reg[JOB_BITS-2:0], din_s};
              if (jcnt != J_FULL) jcnt <= jcnt + 1'b1;
            end
          end
        end
        RUN: begin
          led_cnt    <= led_cnt + 1'b1;
          status_led <= led_cnt[LED_DIV_LOG2];
          if (core_done) begin
            result      <= {core_success, core_nonce};
            success_led <= core_success;
            success_oe  <= core_success;
            local_done  <= 1'b1;
            data_out_oe <= 1'b1;
            status_led  <= 1'b1;
            state       <= REPORT;
          end else if (succ_s) begin
            core_halt   <= 1'b1;
            result      <= '0;
            local_done  <= 1'b1;
            data_out_oe <= 1'b1;
            status_led  <= 1'b1;
            state       <= REPORT;
          end
        end
        REPORT: begin
          status_led <= 1'b1;
          if (dclk_rise) begin
            result <= {result[RW-2:0], 1'b0};
            rcnt   <= rcnt + 1'b1;
            if (rcnt == R_LAST) begin
              data_out_oe <= 1'b0;
              success_oe  <= 1'b0;
              local_done  <= 1'b0;
              status_led  <= 1'b0;
              jcnt        <= '0;
              dcnt        <= '0;
              rcnt        <= '0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shapool_serial_ctrl.sv
// Directed bench for shapool_serial_ctrl.
// Drives the serial bus and a scripted core.
module tb_shapool_serial_ctrl;

  logic        hwclk = 1'b0;
  logic        reset_in = 1'b0;
  logic        data_clk = 1'b0;
  logic        data_in = 1'b0;
  logic        data_out;
  logic        data_out_oe;
  logic        daisy_sel = 1'b0;
  logic        daisy_in = 1'b0;
  logic        daisy_out;
  logic        done_in = 1'b0;
  logic        done_out;
  logic        success_in = 1'b0;
  logic        success_oe;
  logic [63:0] core_job;
  logic [7:0]  core_id;
  logic        core_start;
  logic        core_halt;
  logic        core_done = 1'b0;
  logic        core_success = 1'b0;
  logic [31:0] core_nonce = '0;
  logic        status_led;
  logic        success_led;
  logic        load_err;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_halt = 0;
  int s0, h0;
  logic [32:0] word;

  shapool_serial_ctrl dut (
    .hwclk(hwclk), .reset_in(reset_in),
    .data_clk(data_clk), .data_in(data_in),
    .data_out(data_out), .data_out_oe(data_out_oe),
    .daisy_sel(daisy_sel), .daisy_in(daisy_in),
    .daisy_out(daisy_out),
    .done_in(done_in), .done_out(done_out),
    .success_in(success_in), .success_oe(success_oe),
    .core_job(core_job), .core_id(core_id),
    .core_start(core_start), .core_halt(core_halt),
    .core_done(core_done), .core_success(core_success),
    .core_nonce(core_nonce),
    .status_led(status_led), .success_led(success_led),
    .load_err(load_err)
  );

  always #5 hwclk = ~hwclk;

  always @(posedge hwclk) begin
    if (core_start) n_start++;
    if (core_halt)  n_halt++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge hwclk);
    #1;
  endtask

  task automatic pulse(input logic d);
    data_in  = d;
    daisy_in = d;
    cyc(2);
    data_clk = 1'b1;
    cyc(4);
    data_clk = 1'b0;
    cyc(4);
  endtask

  task automatic send(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pulse(v[i]);
  endtask

  task automatic load(input logic [63:0] job, input int nj,
                      input logic [7:0] id);
    daisy_sel = 1'b0;
    cyc(2);
    send(job, nj);
    daisy_sel = 1'b1;
    cyc(4);
    send({56'd0, id}, 8);
    daisy_sel = 1'b0;
    cyc(8);
  endtask

  task automatic finish_core(input logic s, input logic [31:0] n);
    core_success = s;
    core_nonce   = n;
    core_done    = 1'b1;
    cyc(1);
    core_done    = 1'b0;
    core_success = 1'b0;
    cyc(3);
  endtask

  task automatic read_word(output logic [32:0] w);
    for (int i = 32; i >= 0; i--) begin
      @(negedge hwclk);
      w[i] = data_out;
      pulse(1'b1);
    end
  endtask

  initial begin
    cyc(3);
    @(negedge hwclk);
    chk("rst_oe", {63'd0, data_out_oe}, 64'd0);
    chk("rst_job", core_job, 64'd0);
    chk("rst_led", {63'd0, status_led}, 64'd0);
    chk("rst_err", {63'd0, load_err}, 64'd0);
    reset_in = 1'b1;
    cyc(4);

    // good load and successful result
    load(64'hDEADBEEF_01234567, 64, 8'h5A);
    @(negedge hwclk);
    chk("job", core_job, 64'hDEADBEEF_01234567);
    chk("id", {56'd0, core_id}, 64'h5A);
    chk("starts", 64'(n_start), 64'd1);
    chk("err_ok", {63'd0, load_err}, 64'd0);
    chk("dy_out", {63'd0, daisy_out}, 64'd0);
    chk("run_oe", {63'd0, data_out_oe}, 64'd0);
    finish_core(1'b1, 32'h0000_1F2E);
    @(negedge hwclk);
    chk("rep_oe", {63'd0, data_out_oe}, 64'd1);
    chk("rep_soe", {63'd0, success_oe}, 64'd1);
    chk("rep_sled", {63'd0, success_led}, 64'd1);
    chk("rep_led", {63'd0, status_led}, 64'd1);
    chk("dn_lo", {63'd0, done_out}, 64'd0);
    done_in = 1'b1;
    cyc(5);
    @(negedge hwclk);
    chk("dn_hi", {63'd0, done_out}, 64'd1);
    for (int i = 32; i >= 1; i--) begin
      @(negedge hwclk);
      word[i] = data_out;
      pulse(1'b1);
    end
    @(negedge hwclk);
    chk("soe_32", {63'd0, success_oe}, 64'd1);
    word[0] = data_out;
    pulse(1'b1);
    cyc(2);
    @(negedge hwclk);
    chk("word1", {31'd0, word}, 64'h1_0000_1F2E);
    chk("soe_end", {63'd0, success_oe}, 64'd0);
    chk("oe_end", {63'd0, data_out_oe}, 64'd0);
    chk("dn_end", {63'd0, done_out}, 64'd0);
    chk("sled_hold", {63'd0, success_led}, 64'd1);
    chk("idle_led", {63'd0, status_led}, 64'd0);
    done_in = 1'b0;

    // short job load is rejected, full load recovers
    load(64'h0, 63, 8'h77);
    @(negedge hwclk);
    chk("err_set", {63'd0, load_err}, 64'd1);
    chk("no_start", 64'(n_start), 64'd1);
    load(64'h01234567_89ABCDEF, 64, 8'hC3);
    @(negedge hwclk);
    chk("err_clr", {63'd0, load_err}, 64'd0);
    chk("start2", 64'(n_start), 64'd2);
    chk("job2", core_job, 64'h01234567_89ABCDEF);
    chk("id2", {56'd0, core_id}, 64'hC3);
    chk("dy_out2", {63'd0, daisy_out}, 64'd1);
    chk("sled_clr", {63'd0, success_led}, 64'd0);

    // another device wins: halt and report zeros
    success_in = 1'b1;
    cyc(6);
    @(negedge hwclk);
    chk("halt1", 64'(n_halt), 64'd1);
    chk("halt_oe", {63'd0, data_out_oe}, 64'd1);
    chk("halt_soe", {63'd0, success_oe}, 64'd0);
    success_in = 1'b0;
    read_word(word);
    chk("word0", {31'd0, word}, 64'd0);
    chk("halt_once", 64'(n_halt), 64'd1);

    // core_done coincides with success_in: no halt
    load(64'hA5A5A5A5_5A5A5A5A, 64, 8'h11);
    s0 = n_start;
    h0 = n_halt;
    chk("start3", 64'(s0), 64'd3);
    success_in = 1'b1;
    cyc(2);
    core_nonce = 32'hCAFE_F00D;
    core_done  = 1'b1;
    cyc(1);
    core_done  = 1'b0;
    cyc(4);
    @(negedge hwclk);
    chk("tie_halt", 64'(n_halt), 64'(h0));
    chk("tie_oe", {63'd0, data_out_oe}, 64'd1);
    success_in = 1'b0;
    read_word(word);
    chk("tie_word", {31'd0, word}, 64'h0_CAFE_F00D);

    // reset in the middle of a report
    load(64'h11112222_33334444, 64, 8'h22);
    finish_core(1'b1, 32'h1234_5678);
    @(negedge hwclk);
    chk("pre_soe", {63'd0, success_oe}, 64'd1);
    h0 = n_halt;
    send(64'h1F, 5);
    reset_in = 1'b0;
    cyc(1);
    reset_in = 1'b1;
    @(negedge hwclk);
    chk("mr_oe", {63'd0, data_out_oe}, 64'd0);
    chk("mr_soe", {63'd0, success_oe}, 64'd0);
    chk("mr_led", {63'd0, status_led}, 64'd0);
    chk("mr_sled", {63'd0, success_led}, 64'd0);
    chk("mr_job", core_job, 64'd0);
    cyc(10);
    chk("mr_halt", 64'(n_halt), 64'(h0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
